mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit. It sits beside the ALU and consumes the same forwarded A/B operand buses.
- Its mfhi/mflo read result is muxed with the ALU result into the EX/MEM result path.
- It holds architectural HI/LO and models multi-cycle latency with a busy counter. The hazard unit stalls on busy.
- Supports mult, multu, div, divu, mthi, mtlo, mfhi, mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- md_en  input  1  qualifies md_op this cycle.
- md_op  input  4  operation code, from shared header constants.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- md_out  output  32  read result for mfhi/mflo.

Behaviour:
- Reset (async, active-high):
  - busy=0, HI=0, LO=0, counter=0, pending result registers=0.
  - Asserting reset mid-operation aborts it; no late HI/LO write after reset deasserts.
  - Reset wins over any same-cycle md_en.
- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9-15 are treated as NONE.
- Start (md_en=1, op in MULT..DIVU, busy=0) at edge T:
  - Latch the 64-bit product, or {remainder, quotient}, into pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from T.
- Counting:
  - Counter decrements each edge while busy.
  - On the edge where the counter goes 1->0: HI/LO take the pending values and busy falls.
  - busy is high for exactly N cycles; new HI/LO are visible in the first cycle busy is low.
- Arithmetic:
  - mult: signed 32x32->64. multu: unsigned 32x32->64. HI=upper 32 bits, LO=lower 32 bits.
  - div: signed; quotient truncates toward zero; remainder has the dividend's sign. LO=quotient, HI=remainder.
  - divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): full busy period still elapses; HI/LO keep their previous values.
- mthi/mtlo (md_en=1, busy=0): HI or LO <= A at the edge.
- Ignored while busy: mthi, mtlo and any new start. Upstream stall logic guarantees these never arrive, but the block must stay safe if they do.
- md_out (combinational): HI when md_op=MFHI, LO when md_op=MFLO, else 0. Valid regardless of busy; the hazard unit stalls mfhi/mflo while busy.
- busy does not rise in the start cycle itself. The hazard unit forms stall = busy | (md_en & op in MULT..DIVU & following md instruction).

Decomposition:
- Shared header: MDU_NONE..MDU_MFLO op constants (4-bit) and MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module: none required. Optionally a combinational mdu_calc (signed/unsigned product and quotient/remainder producing 64 bits) to keep the sequential shell small.

Test Plan:
1. mult A=0xFFFFFFFE, B=3 at T: busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with same operands: HI=0x00000002, LO=0xFFFFFFFA.
2. div A=0xFFFFFFF9, B=2: busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2: LO=3, HI=1.
3. With HI=0x11, LO=0x22 preloaded, div A=5, B=0: busy 10 cycles; HI=0x11, LO=0x22 unchanged. div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
4. mult in flight, then mthi A=0x1234 and a second mult while busy: both ignored; final HI/LO match the first mult only; busy stays exactly 5 cycles.
5. Idle: mtlo A=0xABCD at edge; next cycle md_op=MFLO gives md_out=0xABCD; md_op=MFHI gives old HI; md_op=NONE gives md_out=0.
6. Start mult 3*4, assert reset asynchronously mid-cycle 3: busy, HI, LO go 0 immediately. Release reset: HI/LO remain 0 (no pending write); a new start then works normally.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op codes, default latencies and the HI/LO result pair.
package mdu_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdu_pair_t;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_start(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational arithmetic core: 64-bit product or {remainder, quotient}
// for the signed/unsigned multiply and divide ops.
module mdu_unit_calc
  import mdu_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output mdu_pair_t         res,
  output logic              div_zero
);

  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] div_b;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  always_comb begin
    signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = signed_op & a[DATA_W-1];
    b_neg     = signed_op & b[DATA_W-1];
    mag_a     = a_neg ? (~a + 32'd1) : a;
    mag_b     = b_neg ? (~b + 32'd1) : b;
    div_zero  = (b == '0);
    div_b     = div_zero ? 32'd1 : mag_b;
    q_mag     = mag_a / div_b;
    r_mag     = mag_a % div_b;
    quo       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem       = a_neg ? (~r_mag + 32'd1) : r_mag;

    a_ext = signed_op ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    b_ext = signed_op ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod  = a_ext * b_ext;

    res = is_div(op) ? {rem, quo} : prod;
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit: architectural HI/LO with a busy counter that models
// multi-cycle latency; results land in HI/LO on the edge busy falls.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              md_en,
  input  logic [OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  mdu_pair_t        pend;
  logic             pend_wr;
  mdu_pair_t        calc_res;
  logic             div_zero;
  logic             idle_en;

  mdu_unit_calc u_calc (
    .op       (md_op),
    .a        (A),
    .b        (B),
    .res      (calc_res),
    .div_zero (div_zero)
  );

  assign idle_en = md_en & ~busy;

  // Starts, moves and the delayed HI/LO commit; anything arriving while busy is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (pend_wr) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end
    end else if (idle_en && is_start(md_op)) begin
      busy    <= 1'b1;
      pend    <= calc_res;
      pend_wr <= !(is_div(md_op) && div_zero);
      cnt     <= is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (idle_en && (md_op == MDU_MTHI)) begin
      hi <= A;
    end else if (idle_en && (md_op == MDU_MTLO)) begin
      lo <= A;
    end
  end

  always_comb begin
    md_out = '0;
    if (md_op == MDU_MFHI) begin
      md_out = hi;
    end else if (md_op == MDU_MFLO) begin
      md_out = lo;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_en;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_en(md_en), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  function automatic int lat(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd2) ? 5 : 10;
  endfunction

  // Reference: architectural effect of one accepted op on HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin sp = sa * sb; {m_hi, m_lo} = sp; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
      4'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_en = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    md_en = 1'b0; md_op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; md_en = 1'b1; md_op = MDU_MULT; A = 32'd3; B = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    md_en = 1'b0; md_op = MDU_NONE;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_md_out: got %h expected 0", md_out); end
    reset = 1'b0;
    @(posedge clk); #1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult;
    int n;
    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffa", hi, lo); end
    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
    checks++; if (hi !== 32'h2 || lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_result: got %h_%h expected 00000002_fffffffa", hi, lo); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_div;
    int n;
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result: got %h_%h expected ffffffff_fffffffd", hi, lo); end
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 10", n); end
    checks++; if (hi !== 32'd1 || lo !== 32'd3) begin errors++; $display("FAIL divu_result: got %h_%h expected 00000001_00000003", hi, lo); end
    m_hi = 32'd1; m_lo = 32'd3;
  endtask

  task automatic test_div_zero;
    int n;
    issue(MDU_MTHI, 32'h11, 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    issue(MDU_DIV, 32'd5, 32'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divz_busy_rise: got %0b expected 1", busy); end
    wait_idle(n);
    checks++; if (n != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d expected 10", n); end
    checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divz_keep: got %h_%h expected 00000011_00000022", hi, lo); end
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end
    m_hi = 32'd0; m_lo = 32'h80000000;
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(MDU_MULT, 32'h00010000, 32'h00030000);
    issue(MDU_MTHI, 32'h1234, 32'd0);
    issue(MDU_MULT, 32'd5, 32'd5);
    wait_idle(n);
    checks++; if (n + 2 != 5) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 5", n + 2); end
    checks++; if (hi !== 32'd3 || lo !== 32'd0) begin errors++; $display("FAIL ignore_result: got %h_%h expected 00000003_00000000", hi, lo); end
    m_hi = 32'd3; m_lo = 32'd0;
  endtask

  task automatic test_mt_mf;
    issue(MDU_MTLO, 32'hABCD, 32'd0);
    checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_reg: got %h expected 0000abcd", lo); end
    md_op = MDU_MFLO; #1;
    checks++; if (md_out !== 32'hABCD) begin errors++; $display("FAIL mflo_out: got %h expected 0000abcd", md_out); end
    md_op = MDU_MFHI; #1;
    checks++; if (md_out !== 32'd3) begin errors++; $display("FAIL mfhi_out: got %h expected 00000003", md_out); end
    md_op = MDU_NONE; #1;
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL none_out: got %h expected 0", md_out); end
    m_lo = 32'hABCD;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(MDU_MULT, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #4;
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid_clear: got busy=%0b %h_%h expected 0 0_0", busy, hi, lo); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid_no_late_write: got busy=%0b %h_%h expected 0 0_0", busy, hi, lo); end
    issue(MDU_MULT, 32'd3, 32'd4);
    wait_idle(n);
    checks++; if (n != 5 || hi !== 32'd0 || lo !== 32'd12) begin errors++; $display("FAIL reset_mid_restart: got n=%0d %h_%h expected 5 00000000_0000000c", n, hi, lo); end
    m_hi = 32'd0; m_lo = 32'd12;
  endtask

  task automatic test_random;
    int n;
    logic [3:0]  op;
    logic [31:0] a, b, exp_out;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      md_en = 1'b1; md_op = op; A = a; B = b; #1;
      exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
      checks++; if (md_out !== exp_out) begin errors++; $display("FAIL rand_md_out[%0d] op=%0d: got %h expected %h", i, op, md_out, exp_out); end
      @(posedge clk); #1;
      md_en = 1'b0; md_op = 4'd0;
      model(op, a, b);
      if (op >= 4'd1 && op <= 4'd4) begin
        wait_idle(n);
        checks++; if (n != lat(op)) begin errors++; $display("FAIL rand_busy[%0d] op=%0d: got %0d expected %0d", i, op, n, lat(op)); end
      end
      checks++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got busy=%0b %h_%h expected 0 %h_%h", i, op, a, b, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    reset = 1'b1; md_en = 1'b0; md_op = 4'd0; A = '0; B = '0;
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_mt_mf();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
